// File: rtl/shifter_pkg.sv
// Shared shifter definitions: SRO codes, widths and FSM states used by the
// extender, decoder and funnel_shift_seq.
package shifter_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int EXT_W   = 2 * DATA_W - 1;
    localparam int CNT_W   = 3;

    localparam logic [1:0] SRO_SLL = 2'd0;
    localparam logic [1:0] SRO_SRA = 2'd1;
    localparam logic [1:0] SRO_SRL = 2'd2;
    localparam logic [1:0] SRO_ROR = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Last bit pushed out of the 32-bit window for a given op and shift amount.
    function automatic logic sro_carry(input logic [EXT_W-1:0]   ext,
                                       input logic [1:0]         op,
                                       input logic [SHAMT_W-1:0] sa);
        logic [5:0] idx;
        idx = (op == SRO_SLL) ? (6'd63 - {1'b0, sa}) : ({1'b0, sa} - 6'd1);
        return (sa == 5'd0) ? 1'b0 : ext[idx];
    endfunction

endpackage

// File: rtl/funnel_stage.sv
// One log-step of the funnel: conditional right shift of the extended word
// by (1 << stage_i), zero-filled.
module funnel_stage
    import shifter_pkg::*;
(
    input  logic [EXT_W-1:0] data_i,
    input  logic [CNT_W-1:0] stage_i,
    input  logic             en_i,
    output logic [EXT_W-1:0] data_o
);

    // Select the stage's fixed shift distance when this shamt bit is set.
    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (stage_i)
                3'd0:    data_o = data_i >> 5'd1;
                3'd1:    data_o = data_i >> 5'd2;
                3'd2:    data_o = data_i >> 5'd4;
                3'd3:    data_o = data_i >> 5'd8;
                3'd4:    data_o = data_i >> 5'd16;
                default: data_o = data_i;
            endcase
        end else begin
            data_o = data_i;
        end
    end

endmodule

// File: rtl/funnel_shift_seq.sv
// Iterative funnel shifter: extracts a 32-bit result from the 63-bit extended
// operand in 5 log-steps. Optional carry_out under `SHIFTER_CARRY_EN.
module funnel_shift_seq
    import shifter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [EXT_W-1:0]   ext_data,
    input  logic [1:0]         sro,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  result,
    output logic               out_valid,
`ifdef SHIFTER_CARRY_EN
    output logic               carry_out,
`endif
    input  logic               out_ready
);

    state_e              state_q, state_d;
    logic [EXT_W-1:0]    work_q, work_d;
    logic [SHAMT_W-1:0]  amt_q, amt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic [EXT_W-1:0]    stage_out_s;
`ifdef SHIFTER_CARRY_EN
    logic                carry_q, carry_d;
`endif

    funnel_stage u_stage (
        .data_i  (work_q),
        .stage_i (cnt_q),
        .en_i    (amt_q[cnt_q]),
        .data_o  (stage_out_s)
    );

    // Next-state and datapath control for IDLE -> SHIFT -> DONE.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        amt_d       = amt_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
`ifdef SHIFTER_CARRY_EN
        carry_d     = carry_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    work_d  = ext_data;
                    // SLL is a right funnel by 31-shamt on {Data,31'b0}.
                    amt_d   = (sro == SRO_SLL) ? ~shamt : shamt;
                    cnt_d   = 3'd0;
                    state_d = SHIFT;
`ifdef SHIFTER_CARRY_EN
                    carry_d = sro_carry(ext_data, sro, shamt);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d = stage_out_s;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd4) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = stage_out_s[DATA_W-1:0];
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        in_ready_d = (state_d == IDLE);
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= {EXT_W{1'b0}};
            amt_q       <= {SHAMT_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            result_q    <= {DATA_W{1'b0}};
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            amt_q       <= amt_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

`ifdef SHIFTER_CARRY_EN
    // Carry captured at accept, held until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign carry_out = carry_q;
`endif

    assign in_ready  = in_ready_q;
    assign result    = result_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_funnel_shift_seq.sv
// Directed bench for funnel_shift_seq; carry checks only when built with
// SHIFTER_CARRY_EN.
module tb_funnel_shift_seq;

    logic        clk;
    logic        rst_n;
    logic [62:0] ext_data;
    logic [1:0]  sro;
    logic [4:0]  shamt;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic        out_valid;
    logic        out_ready;
`ifdef SHIFTER_CARRY_EN
    logic        carry_out;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    funnel_shift_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ext_data  (ext_data),
        .sro       (sro),
        .shamt     (shamt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .out_valid (out_valid),
`ifdef SHIFTER_CARRY_EN
        .carry_out (carry_out),
`endif
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [62:0] mk_ext(input logic [1:0] op, input logic [31:0] d);
        case (op)
            2'd0:    return {d, 31'b0};
            2'd1:    return {{31{d[31]}}, d};
            2'd2:    return {31'b0, d};
            default: return {d[30:0], d};
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] d,
                          input logic [4:0] sa, input logic [31:0] exp_r,
                          input logic exp_c, input int stall);
        int n;
        check({tag, ".ready_pre"}, {63'b0, in_ready}, 64'd1);
        ext_data = mk_ext(op, d);
        sro      = op;
        shamt    = sa;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ext_data = ~ext_data;
        sro      = ~op;
        shamt    = ~sa;
        check({tag, ".ready_busy"}, {63'b0, in_ready}, 64'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".latency"}, 64'(n), 64'd5);
        check({tag, ".result"}, {32'b0, result}, {32'b0, exp_r});
`ifdef SHIFTER_CARRY_EN
        check({tag, ".carry"}, {63'b0, carry_out}, {63'b0, exp_c});
`endif
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, ".stall_res"}, {32'b0, result}, {32'b0, exp_r});
            check({tag, ".stall_vld"}, {63'b0, out_valid}, 64'd1);
            check({tag, ".stall_rdy"}, {63'b0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".vld_post"}, {63'b0, out_valid}, 64'd0);
        check({tag, ".ready_post"}, {63'b0, in_ready}, 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        ext_data  = 63'd0;
        sro       = 2'd0;
        shamt     = 5'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst.out_valid", {63'b0, out_valid}, 64'd0);
        check("rst.result", {32'b0, result}, 64'd0);
        check("rst.in_ready", {63'b0, in_ready}, 64'd1);
`ifdef SHIFTER_CARRY_EN
        check("rst.carry", {63'b0, carry_out}, 64'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("sll4",  2'd0, 32'h00000001, 5'd4,  32'h00000010, 1'b0, 0);
        run_op("sra4",  2'd1, 32'h80000000, 5'd4,  32'hF8000000, 1'b0, 0);
        run_op("srl4",  2'd2, 32'h80000000, 5'd4,  32'h08000000, 1'b0, 0);
        run_op("ror1",  2'd3, 32'h00000001, 5'd1,  32'h80000000, 1'b1, 0);
        run_op("sll0",  2'd0, 32'hA5A5A5A5, 5'd0,  32'hA5A5A5A5, 1'b0, 0);
        run_op("sra0",  2'd1, 32'hA5A5A5A5, 5'd0,  32'hA5A5A5A5, 1'b0, 0);
        run_op("srl0",  2'd2, 32'hA5A5A5A5, 5'd0,  32'hA5A5A5A5, 1'b0, 0);
        run_op("ror0",  2'd3, 32'hA5A5A5A5, 5'd0,  32'hA5A5A5A5, 1'b0, 0);
        run_op("sll31", 2'd0, 32'h00000003, 5'd31, 32'h80000000, 1'b1, 0);
        run_op("srl31", 2'd2, 32'hF0000000, 5'd31, 32'h00000001, 1'b1, 0);
        run_op("sra31", 2'd1, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 0);
        run_op("ror8",  2'd3, 32'h12345678, 5'd8,  32'h78123456, 1'b0, 0);
        run_op("stall", 2'd2, 32'h0000F000, 5'd12, 32'h0000000F, 1'b0, 10);

        ext_data = mk_ext(2'd0, 32'hFFFFFFFF);
        sro      = 2'd0;
        shamt    = 5'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort.out_valid", {63'b0, out_valid}, 64'd0);
        check("abort.in_ready", {63'b0, in_ready}, 64'd1);
        check("abort.result", {32'b0, result}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after_abort", 2'd0, 32'h0000000F, 5'd8, 32'h00000F00, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
